// File: rtl/down_counter_8b.sv
// down_counter_8b: loadable down-counter / interval timer.
//
// A value is loaded, then start begins counting down from it. Q decrements on
// every clock with T=1 while running; reaching zero raises a one-cycle done
// pulse. With AUTO_RELOAD=1 the counter reloads the last loaded value at
// terminal count and keeps running instead of returning to idle.
//
// Ports:
//   clk    in   1      rising-edge clock
//   clr    in   1      asynchronous active-high reset
//   load   in   1      Q <= din, reload value <= din, return to idle
//   din    in   WIDTH  load value
//   start  in   1      begin counting from current Q (idle only)
//   stop   in   1      abort counting, Q holds, return to idle
//   T      in   1      count enable while running
//   Q      out  WIDTH  current count (registered)
//   busy   out  1      high while running (registered)
//   zero   out  1      Q == 0 (combinational)
//   done   out  1      one-cycle terminal-count pulse (registered)
module down_counter_8b #(
    parameter int unsigned WIDTH       = 8,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             stop,
    input  logic             T,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             zero,
    output logic             done
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= StIdle;
            q_q      <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Priority: load > stop > start > T. done defaults low so it can only
    // ever be a single-cycle pulse.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            // Also discards any terminal count that would land on this edge.
            q_d      = din;
            reload_d = din;
            state_d  = StIdle;
        end else if (stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (q_q != '0) begin
                            state_d = StRun;
                        end else begin
                            // Starting an already-expired timer just reports done.
                            done_d = 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (T) begin
                        if (q_q == WIDTH'(1)) begin
                            done_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                q_d = reload_q;
                            end else begin
                                q_d     = '0;
                                state_d = StIdle;
                            end
                        end else if (q_q != '0) begin
                            q_d = q_q - WIDTH'(1);
                        end
                        // q_q == 0 while running is unreachable; hold to rule out underflow.
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign Q    = q_q;
    assign busy = (state_q == StRun);
    assign zero = (q_q == '0);
    assign done = done_q;

endmodule

// File: tb/tb_down_counter_8b.sv
module tb_down_counter_8b;

    logic       clk;
    logic       clr;
    logic       load;
    logic [7:0] din;
    logic       start;
    logic       stop;
    logic       t;

    logic [7:0] q0, q1;
    logic       busy0, busy1, zero0, zero1, done0, done1;

    int total = 0;
    int bad   = 0;

    down_counter_8b #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_oneshot (
        .clk  (clk),
        .clr  (clr),
        .load (load),
        .din  (din),
        .start(start),
        .stop (stop),
        .T    (t),
        .Q    (q0),
        .busy (busy0),
        .zero (zero0),
        .done (done0)
    );

    down_counter_8b #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_reload (
        .clk  (clk),
        .clr  (clr),
        .load (load),
        .din  (din),
        .start(start),
        .stop (stop),
        .T    (t),
        .Q    (q1),
        .busy (busy1),
        .zero (zero1),
        .done (done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       ld;
        logic [7:0] d;
        logic       st;
        logic       sp;
        logic       en;
        logic [7:0] q;
        logic       busy;
        logic       zero;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ld, input logic [7:0] d, input logic st, input logic sp,
                       input logic en, input logic [7:0] q, input logic b, input logic z,
                       input logic dn);
        vec_t v;
        v.ld = ld; v.d = d; v.st = st; v.sp = sp; v.en = en;
        v.q = q; v.busy = b; v.zero = z; v.done = dn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [7:0] d, input logic st, input logic sp,
                         input logic en);
        load = ld; din = d; start = st; stop = sp; t = en;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1;
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("reset_q", q0, 0);
        chk("reset_busy", busy0, 0);
        chk("reset_zero", zero0, 1);
        chk("reset_done", done0, 0);
        #1 clr = 1'b0;
        step();

        //   ld  din    st  sp  T    Q      busy zero done
        add(1, 8'd5,  0, 0, 0, 8'd5,  0, 0, 0);  // one-shot
        add(0, 8'd0,  1, 0, 0, 8'd5,  1, 0, 0);  // start: no decrement
        add(0, 8'd0,  0, 0, 1, 8'd4,  1, 0, 0);
        add(0, 8'd0,  0, 0, 1, 8'd3,  1, 0, 0);
        add(0, 8'd0,  0, 0, 1, 8'd2,  1, 0, 0);
        add(0, 8'd0,  0, 0, 1, 8'd1,  1, 0, 0);
        add(0, 8'd0,  0, 0, 1, 8'd0,  0, 1, 1);  // terminal count
        add(0, 8'd0,  0, 0, 1, 8'd0,  0, 1, 0);  // done not held
        add(0, 8'd0,  1, 0, 0, 8'd0,  0, 1, 1);  // start at zero
        add(0, 8'd0,  0, 0, 0, 8'd0,  0, 1, 0);
        add(1, 8'd10, 0, 0, 0, 8'd10, 0, 0, 0);  // pause / stop
        add(0, 8'd0,  1, 0, 0, 8'd10, 1, 0, 0);
        add(0, 8'd0,  0, 0, 1, 8'd9,  1, 0, 0);
        add(0, 8'd0,  0, 0, 0, 8'd9,  1, 0, 0);  // paused, still busy
        add(0, 8'd0,  0, 0, 1, 8'd8,  1, 0, 0);
        add(0, 8'd0,  0, 0, 0, 8'd8,  1, 0, 0);
        add(0, 8'd0,  0, 0, 1, 8'd7,  1, 0, 0);
        add(0, 8'd0,  0, 0, 1, 8'd6,  1, 0, 0);
        add(0, 8'd0,  0, 1, 0, 8'd6,  0, 0, 0);  // stop at 6
        add(0, 8'd0,  0, 0, 1, 8'd6,  0, 0, 0);  // T ignored in idle
        add(0, 8'd0,  1, 0, 0, 8'd6,  1, 0, 0);  // resume
        add(0, 8'd0,  0, 0, 1, 8'd5,  1, 0, 0);
        add(0, 8'd0,  1, 0, 1, 8'd4,  1, 0, 0);  // start ignored in run
        add(1, 8'd3,  1, 0, 0, 8'd3,  0, 0, 0);  // load beats start
        add(0, 8'd0,  1, 0, 0, 8'd3,  1, 0, 0);
        add(0, 8'd0,  0, 0, 1, 8'd2,  1, 0, 0);
        add(0, 8'd0,  0, 0, 1, 8'd1,  1, 0, 0);
        add(1, 8'd9,  0, 0, 1, 8'd9,  0, 0, 0);  // load on terminal edge
        add(0, 8'd0,  1, 1, 0, 8'd9,  0, 0, 0);  // stop beats start
        add(1, 8'd0,  0, 0, 0, 8'd0,  0, 1, 0);  // load zero
        add(0, 8'd0,  1, 0, 1, 8'd0,  0, 1, 1);  // single done pulse
        add(0, 8'd0,  0, 0, 1, 8'd0,  0, 1, 0);  // busy never rose

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].d, vecs[i].st, vecs[i].sp, vecs[i].en);
            step();
            chk($sformatf("vec%0d_q", i), q0, vecs[i].q);
            chk($sformatf("vec%0d_busy", i), busy0, vecs[i].busy);
            chk($sformatf("vec%0d_zero", i), zero0, vecs[i].zero);
            chk($sformatf("vec%0d_done", i), done0, vecs[i].done);
        end

        // Asynchronous reset in mid-count.
        drive(1'b1, 8'd200, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        repeat (50) step();
        chk("midcount_q", q0, 150);
        chk("midcount_busy", busy0, 1);
        #3 clr = 1'b1;
        #1;
        chk("async_clr_q", q0, 0);
        chk("async_clr_busy", busy0, 0);
        chk("async_clr_done", done0, 0);
        chk("async_clr_zero", zero0, 1);
        #2 clr = 1'b0;
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("after_clr_q", q0, 0);
        chk("after_clr_busy", busy0, 0);

        // Full-range count from 255.
        drive(1'b1, 8'd255, 1'b0, 1'b0, 1'b1);
        step();
        chk("max_load_q", q0, 255);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        step();
        chk("max_start_q", q0, 255);
        chk("max_start_busy", busy0, 1);
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 254; i >= 0; i--) begin
            step();
            chk($sformatf("max_q_at_%0d", i), q0, i);
            chk($sformatf("max_done_at_%0d", i), done0, (i == 0) ? 1 : 0);
        end
        step();
        chk("max_hold_q", q0, 0);
        chk("max_hold_busy", busy0, 0);
        chk("max_hold_done", done0, 0);

        // Auto-reload instance: period of 3 with done on every reload.
        drive(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk("ar_start_q", q1, 3);
        chk("ar_start_busy", busy1, 1);
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            int exp_q;
            exp_q = (i % 3 == 0) ? 2 : (i % 3 == 1) ? 1 : 3;
            step();
            chk($sformatf("ar_q_%0d", i), q1, exp_q);
            chk($sformatf("ar_done_%0d", i), done1, (exp_q == 3) ? 1 : 0);
            chk($sformatf("ar_busy_%0d", i), busy1, 1);
            chk($sformatf("ar_zero_%0d", i), zero1, 0);
        end
        drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk("ar_stop_busy", busy1, 0);
        chk("ar_stop_q", q1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
